// File: rtl/barrel_pkg.sv
// ---------------------------------------------------------------------------
// barrel_pkg
// Shared definitions for the barrel_shift_sequencer slice:
//   - data / amount widths and the largest single-pass shift
//   - sequencer state encoding
//   - shift-direction constants
//   - step selection helper used by the sequencer's step mux
// ---------------------------------------------------------------------------
package barrel_pkg;

    // Data width is fixed by the barrel_shifter datapath.
    localparam int DATA_W   = 4;
    // Command shift-amount width; largest requested shift is 2**AMT_W-1 = 7.
    localparam int AMT_W    = 3;
    // Largest shift the barrel_shifter performs in a single pass.
    localparam int STEP_MAX = 3;
    // Width of the barrel_shifter amount input (holds 0..STEP_MAX).
    localparam int STEP_W   = 2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Size of the next pass: the full remainder when it fits in one pass,
    // otherwise the largest pass the shifter supports.
    function automatic logic [STEP_W-1:0] step_of(input logic [AMT_W-1:0] rem);
        logic [STEP_W-1:0] step;
        if (rem > AMT_W'(STEP_MAX)) begin
            step = STEP_W'(STEP_MAX);
        end else begin
            step = rem[STEP_W-1:0];
        end
        return step;
    endfunction

endpackage

// File: rtl/barrel_shift_sequencer_checker.sv
// ---------------------------------------------------------------------------
// barrel_shift_sequencer_checker
// Property checker for the barrel_shift_sequencer handshake outputs.
// Ports (all inputs, observed only):
//   clk, rst_n            clock and asynchronous active-low reset
//   in_ready, busy        command-side status
//   out_valid, out_ready  result handshake
//   out_data              result value
// ---------------------------------------------------------------------------
module barrel_shift_sequencer_checker
    import barrel_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    input logic              in_ready,
    input logic              busy,
    input logic              out_valid,
    input logic              out_ready,
    input logic [DATA_W-1:0] out_data
);

    // Ready for a command exactly when not working on one.
    a_ready_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        in_ready == !busy);

    // A pending result always belongs to an in-flight command.
    a_valid_implies_busy: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> busy);

    // A stalled result is held unchanged until taken.
    a_result_held: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: rtl/barrel_shifter.sv
// ---------------------------------------------------------------------------
// barrel_shifter
// Combinational 4-bit logical barrel shifter, shift amount 0..3, zero fill.
// Ports:
//   data_in   in  DATA_W  operand
//   shift_amt in  STEP_W  shift amount 0..3
//   dir       in  1       0 = left, 1 = right
//   data_out  out DATA_W  shifted operand
// ---------------------------------------------------------------------------
module barrel_shifter
    import barrel_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [STEP_W-1:0] shift_amt,
    input  logic              dir,
    output logic [DATA_W-1:0] data_out
);

    // Logical shift in the requested direction; vacated bits fill with zero.
    always_comb begin
        data_out = {DATA_W{1'b0}};
        if (dir == DIR_RIGHT) begin
            data_out = data_in >> shift_amt;
        end else begin
            data_out = data_in << shift_amt;
        end
    end

endmodule

// File: rtl/barrel_shift_sequencer.sv
// ---------------------------------------------------------------------------
// barrel_shift_sequencer
// Command front-end for the 0..3 barrel_shifter. Accepts {data, amount 0..7,
// dir}, splits amounts above 3 into passes of at most 3 that loop through a
// single shifter instance, and presents the result on a valid/ready output.
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       command valid
//   in_ready   out  1       command accepted when in_valid & in_ready
//   in_data    in   DATA_W  operand
//   in_amt     in   AMT_W   total shift amount
//   in_dir     in   1       0 = left, 1 = right
//   out_valid  out  1       result valid
//   out_ready  in   1       consumer accepts result
//   out_data   out  DATA_W  shifted result
//   busy       out  1       high while a command is shifting or waiting
// All outputs are registers; their next values are decoded from the
// next state so they line up exactly with the state register.
// ---------------------------------------------------------------------------
module barrel_shift_sequencer
    import barrel_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_dir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_t              state_r;
    state_t              state_s;
    logic [DATA_W-1:0]   acc_r;
    logic [DATA_W-1:0]   acc_s;
    logic [AMT_W-1:0]    rem_r;
    logic [AMT_W-1:0]    rem_s;
    logic                dir_r;
    logic                dir_s;
    logic [DATA_W-1:0]   out_data_r;
    logic [DATA_W-1:0]   out_data_s;
    logic                out_valid_r;
    logic                in_ready_r;
    logic                busy_r;
    logic [STEP_W-1:0]   step_s;
    logic [DATA_W-1:0]   shift_out_s;

    // Size of the pass applied this cycle.
    assign step_s = step_of(rem_r);

    barrel_shifter u_shift (
        .data_in   (acc_r),
        .shift_amt (step_s),
        .dir       (dir_r),
        .data_out  (shift_out_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath next-value decode.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        rem_s      = rem_r;
        dir_s      = dir_r;
        out_data_s = out_data_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    acc_s = in_data;
                    rem_s = in_amt;
                    dir_s = in_dir;
                    if (in_amt == {AMT_W{1'b0}}) begin
                        // Nothing to shift: the operand is the result.
                        state_s    = DONE;
                        out_data_s = in_data;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                acc_s = shift_out_s;
                // step never exceeds rem, so this cannot wrap.
                rem_s = rem_r - AMT_W'(step_s);
                if (rem_r == AMT_W'(step_s)) begin
                    // Final pass: capture the result alongside the state change.
                    state_s    = DONE;
                    out_data_s = shift_out_s;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath registers: accumulator, remaining amount, direction, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {DATA_W{1'b0}};
            rem_r      <= {AMT_W{1'b0}};
            dir_r      <= DIR_LEFT;
            out_data_r <= {DATA_W{1'b0}};
        end else begin
            acc_r      <= acc_s;
            rem_r      <= rem_s;
            dir_r      <= dir_s;
            out_data_r <= out_data_s;
        end
    end

    // Handshake/status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_barrel_shift_sequencer
// Directed, table-driven bench for barrel_shift_sequencer plus hand-written
// multi-cycle sequences (pass sizes, output stall, mid-command reset,
// back-to-back sweep against a one-step reference shift).
// ---------------------------------------------------------------------------
module tb_barrel_shift_sequencer;
    import barrel_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic [2:0] in_amt = 3'd0;
    logic       in_dir = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    barrel_shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    barrel_shift_sequencer_checker u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    typedef struct {
        logic [3:0] data;
        logic [2:0] amt;
        logic       dir;
        logic [3:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Whole shift done in one step, independent of pass splitting.
    function automatic logic [3:0] ref_shift(input logic [3:0] d, input logic [2:0] a,
                                             input logic dr);
        logic [7:0] wide;
        wide = {4'd0, d};
        if (dr) begin
            return 4'(wide >> a);
        end else begin
            wide = wide << a;
            return wide[3:0];
        end
    endfunction

    // Wait (bounded) at negedges for in_ready.
    task automatic wait_ready(input string name);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_ready"}, int'(in_ready), 1);
    endtask

    // Issue one command, check latency and result, then take it.
    task automatic run_cmd(input logic [3:0] d, input logic [2:0] a, input logic dr,
                           input logic [3:0] exp_d, input int exp_lat, input string name);
        int lat;
        wait_ready(name);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dr;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        in_amt   = 3'($urandom);
        in_dir   = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 10) begin
            check({name, "_busy"}, int'(busy), 1);
            @(negedge clk);
            lat++;
        end
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_data"}, int'(out_data), int'(exp_d));
        check({name, "_inrdy_lo"}, int'(in_ready), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_valid_clr"}, int'(out_valid), 0);
        check({name, "_inrdy_back"}, int'(in_ready), 1);
    endtask

    initial begin
        int passes[3];
        logic [3:0] expq[$];
        int next_idx;
        int got;
        int cyc;
        int idx;

        vecs[0] = '{4'b1010, 3'd0, 1'b0, 4'b1010, 1};
        vecs[1] = '{4'b1010, 3'd3, 1'b1, 4'b0001, 2};
        vecs[2] = '{4'b0001, 3'd7, 1'b0, 4'b0000, 4};
        vecs[3] = '{4'b0101, 3'd2, 1'b0, 4'b0100, 2};
        vecs[4] = '{4'b1001, 3'd1, 1'b1, 4'b0100, 2};
        vecs[5] = '{4'b1111, 3'd4, 1'b1, 4'b0000, 3};
        vecs[6] = '{4'b0110, 3'd1, 1'b0, 4'b1100, 2};
        vecs[7] = '{4'b1000, 3'd3, 1'b1, 4'b0001, 2};
        vecs[8] = '{4'b0111, 3'd5, 1'b0, 4'b0000, 3};
        vecs[9] = '{4'b1011, 3'd2, 1'b1, 4'b0010, 2};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].exp_data,
                    vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Pass sizes for amount 7: 3, 3, 1.
        passes[0] = 3; passes[1] = 3; passes[2] = 1;
        wait_ready("pass");
        in_valid = 1'b1; in_data = 4'b0001; in_amt = 3'd7; in_dir = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int p = 0; p < 3; p++) begin
            check($sformatf("pass%0d_amt", p), int'(dut.u_shift.shift_amt), passes[p]);
            check($sformatf("pass%0d_nvalid", p), int'(out_valid), 0);
            @(negedge clk);
        end
        check("pass_valid", int'(out_valid), 1);
        check("pass_data", int'(out_data), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Output stall for 3 cycles, new command presented meanwhile.
        wait_ready("stall");
        in_valid = 1'b1; in_data = 4'b0101; in_amt = 3'd2; in_dir = 1'b0;
        @(negedge clk);
        in_data = 4'b0011; in_amt = 3'd1; in_dir = 1'b0;
        @(negedge clk);
        check("stall_valid0", int'(out_valid), 1);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", s), int'(out_valid), 1);
            check($sformatf("stall%0d_data", s), int'(out_data), 4);
            check($sformatf("stall%0d_busy", s), int'(busy), 1);
            check($sformatf("stall%0d_inrdy", s), int'(in_ready), 0);
        end
        // Handshake with in_valid still high: the new command waits in IDLE.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("simul_idle_ready", int'(in_ready), 1);
        check("simul_idle_nvalid", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("simul_accepted_busy", int'(busy), 1);
        @(negedge clk);
        check("simul_valid", int'(out_valid), 1);
        check("simul_data", int'(out_data), 6);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the second SHIFT cycle.
        wait_ready("rstmid");
        in_valid = 1'b1; in_data = 4'b0001; in_amt = 3'd7; in_dir = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("rstmid_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", int'(out_valid), 0);
        check("rstmid_ready", int'(in_ready), 1);
        check("rstmid_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            check($sformatf("rstmid_quiet%0d", r), int'(out_valid), 0);
        end
        run_cmd(4'b1111, 3'd1, 1'b1, 4'b0111, 2, "post_rst");

        // Back-to-back sweep of every data x amount x dir, scrambled order.
        next_idx = 0;
        got = 0;
        cyc = 0;
        out_ready = 1'b1;
        while ((next_idx < 256 || expq.size() > 0) && cyc < 6000) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("b2b_spurious", 1, 0);
                end else begin
                    check("b2b_data", int'(out_data), int'(expq.pop_front()));
                    got++;
                end
            end
            if (in_ready) begin
                if (next_idx < 256) begin
                    idx = (next_idx * 37 + 11) % 256;
                    in_valid = 1'b1;
                    in_data  = 4'(idx);
                    in_amt   = 3'(idx >> 4);
                    in_dir   = 1'(idx >> 7);
                    expq.push_back(ref_shift(in_data, in_amt, in_dir));
                    next_idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                // Ignored while busy; keep in_valid high with junk.
                in_data = 4'($urandom);
                in_amt  = 3'($urandom);
                in_dir  = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_count", got, 256);
        check("b2b_timeout", int'(cyc < 6000), 1);
        repeat (3) @(negedge clk);
        check("b2b_no_extra", int'(out_valid), 0);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
